pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the multicycle RISC-V datapath. Successor to the single-mode PC incrementer.
- Holds the PC register and advances it only in the fetch state of the control FSM.
- Supports four next-PC modes: sequential, PC-relative branch/jal, register-indirect jalr, and explicit hold.
- Also provides the previous PC, the return address (PC+STEP) and a retired-instruction counter to the rest of the datapath.

Parameters:
- XLEN, 32, width of PC, rs1 and all address outputs.
- IMM_W, 13, width of signed immediate input; sign-extended to XLEN.
- STEP, 4, sequential increment (4 for byte-addressed memory, 1 for word-addressed instruction memory).
- RESET_PC, 0, PC value after reset.
- STATE_W, 3, width of estado.
- FETCH_STATE, 3'b000, estado encoding in which PC may update.
- CNT_W, 32, width of instret counter.
- TRAP_VEC, 32'h0000_0040, redirect target for misaligned fetch (optional feature only).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- estado  input  STATE_W  current control-FSM state.
- pcsrc  input  2  next-PC select: 00 sequential, 01 PC+sext(imm), 10 (rs1+sext(imm)) with bit0 cleared, 11 hold.
- immediate  input  IMM_W  signed offset; two's complement.
- rs1  input  XLEN  base register value for jalr.
- stall  input  1  when 1, blocks any PC update.
- PC  output  XLEN  current program counter (registered).
- pc_prev  output  XLEN  PC value before the most recent update (registered).
- pc_ret  output  XLEN  PC + STEP, combinational from PC; jal/jalr link value.
- instret  output  CNT_W  number of PC updates since reset.
- misalign  output  1  one-cycle pulse on misaligned target (optional feature; otherwise constant 0).

Behaviour:
- Reset (rst=1 at a rising edge): PC=RESET_PC, pc_prev=RESET_PC, instret=0, misalign=0. Reset has priority over every other input, including a reset asserted mid-fetch.
- Update condition: upd = (estado == FETCH_STATE) && !stall && (pcsrc != 2'b11). When upd=0, PC, pc_prev and instret hold their values.
- Target computation (XLEN arithmetic, modulo 2^XLEN, wrap-around silent):
  - seq = PC + STEP
  - rel = PC + sext(immediate)
  - ind = (rs1 + sext(immediate)) & ~1
- On an upd cycle: PC <= selected target; pc_prev <= old PC; instret <= instret+1, wrapping at 2^CNT_W.
- The selected target is the sole assignment of PC in that cycle. No later default increment may override a branch or jump.
- Latency: new PC is visible one cycle after the update edge. pc_ret follows PC combinationally.
- Hold (pcsrc=11) in the fetch state is not an update: instret does not count.
- Relative target with immediate=0 yields PC unchanged but still counts as an update (self-loop).
- Sign extension: immediate MSB replicated into bits XLEN-1..IMM_W.
- PC=2^XLEN-STEP with seq wraps to 0.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- Defined:
  - On an upd cycle, if the selected target is misaligned (target mod STEP != 0, checked only when STEP is a power of two greater than 1): PC <= TRAP_VEC; pc_prev <= old PC; instret increments; misalign=1 for exactly the next cycle.
  - misalign is registered and clears on the following cycle unless another misaligned update occurs.
- Undefined: target loaded unmodified; misalign tied 0.

Test Plan:
- Reset then four fetch cycles with pcsrc=00, STEP=4 -> PC 0,4,8,12,16; pc_prev trails by one update; instret=4.
- PC=0x100, pcsrc=01, immediate=13'h1FF8 (-8), estado=FETCH -> PC=0xF8, pc_prev=0x100, pc_ret=0xFC.
- rs1=0x2001, immediate=0x4, pcsrc=10 -> PC=0x2004; stall=1 or estado=3'b010 for 3 cycles -> PC, pc_prev, instret unchanged.
- pcsrc=11 in fetch for 2 cycles -> PC held, instret unchanged; rst=1 during a fetch with pcsrc=01 -> PC=RESET_PC, instret=0 next cycle.
- PC=0xFFFF_FFFC, pcsrc=00 -> PC=0; instret at 2^CNT_W-1 -> wraps to 0.
- PC_MISALIGN_TRAP_EN defined, PC=0x100, immediate=0x6, pcsrc=01 -> PC=0x40, misalign=1 for one cycle then 0; undefined -> PC=0x106, misalign=0.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the multicycle RISC-V datapath.
// Holds the PC, advances it only in the fetch state, and supports sequential,
// PC-relative, register-indirect and hold next-PC modes. It also exports the
// previous PC, the link value (PC+STEP) and a retired-instruction counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN. When it is defined, a misaligned
// target redirects the PC to TRAP_VEC and raises a one-cycle misalign pulse.
module pc_unit #(
    parameter int                 XLEN        = 32,
    parameter int                 IMM_W       = 13,
    parameter int                 STEP        = 4,
    parameter logic [XLEN-1:0]    RESET_PC    = '0,
    parameter int                 STATE_W     = 3,
    parameter logic [STATE_W-1:0] FETCH_STATE = '0,
    parameter int                 CNT_W       = 32,
    parameter logic [XLEN-1:0]    TRAP_VEC    = XLEN'('h40)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] estado,
    input  logic [1:0]         pcsrc,
    input  logic [IMM_W-1:0]   immediate,
    input  logic [XLEN-1:0]    rs1,
    input  logic               stall,
    output logic [XLEN-1:0]    PC,
    output logic [XLEN-1:0]    pc_prev,
    output logic [XLEN-1:0]    pc_ret,
    output logic [CNT_W-1:0]   instret,
    output logic               misalign
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // Alignment is only meaningful when STEP is a power of two above 1.
    localparam bit              CHECK_ALIGN = (STEP > 1) && ((STEP & (STEP - 1)) == 0);
    localparam logic [XLEN-1:0] ALIGN_MASK  = XLEN'(STEP - 1);

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_REL  = 2'b01;
    localparam logic [1:0] SEL_IND  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    logic [XLEN-1:0]  pc_reg;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  pc_prev_reg;
    logic [CNT_W-1:0] instret_reg;
    logic [CNT_W-1:0] instret_next;
    logic             misalign_reg;
    logic             misalign_next;

    logic [XLEN-1:0]  imm_sext;
    logic [XLEN-1:0]  seq_target;
    logic [XLEN-1:0]  rel_target;
    logic [XLEN-1:0]  ind_sum;
    logic [XLEN-1:0]  ind_target;
    logic [XLEN-1:0]  sel_target;
    logic             target_misaligned;
    logic             upd;

    // Sign extension: low bits copy the immediate, upper bits replicate its MSB.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_sext
            if (gi < IMM_W) begin : g_low
                assign imm_sext[gi] = immediate[gi];
            end else begin : g_high
                assign imm_sext[gi] = immediate[IMM_W-1];
            end
        end
    endgenerate

    // Candidate targets; all arithmetic wraps silently modulo 2^XLEN.
    assign seq_target = pc_reg + XLEN'(STEP);
    assign rel_target = pc_reg + imm_sext;
    assign ind_sum    = rs1 + imm_sext;
    assign ind_target = {ind_sum[XLEN-1:1], 1'b0};

    // Hold is never an update, so the counter does not see it.
    assign upd = (estado == FETCH_STATE) && !stall && (pcsrc != SEL_HOLD);

    // Next-PC selection: the chosen target is the only value written to PC.
    always_comb begin
        sel_target = pc_reg;
        case (pcsrc)
            SEL_SEQ: sel_target = seq_target;
            SEL_REL: sel_target = rel_target;
            SEL_IND: sel_target = ind_target;
            default: sel_target = pc_reg;
        endcase
        target_misaligned = CHECK_ALIGN && ((sel_target & ALIGN_MASK) != '0);
        pc_next       = (TRAP_EN && target_misaligned) ? TRAP_VEC : sel_target;
        instret_next  = instret_reg + CNT_W'(1);
        misalign_next = TRAP_EN && upd && target_misaligned;
    end

    // State registers; reset overrides any update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            pc_prev_reg  <= RESET_PC;
            instret_reg  <= '0;
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= misalign_next;
            if (upd) begin
                pc_reg      <= pc_next;
                pc_prev_reg <= pc_reg;
                instret_reg <= instret_next;
            end
        end
    end

    assign PC       = pc_reg;
    assign pc_prev  = pc_prev_reg;
    assign pc_ret   = pc_reg + XLEN'(STEP);
    assign instret  = instret_reg;
    assign misalign = TRAP_EN ? misalign_reg : 1'b0;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit.
// A second instance with a 3-bit counter exercises the instret wrap boundary.
// Honours PC_MISALIGN_TRAP_EN for the misaligned-target expectations.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  estado;
    logic [1:0]  pcsrc;
    logic [12:0] immediate;
    logic [31:0] rs1;
    logic        stall;

    logic [31:0] pc_o, pc_prev_o, pc_ret_o;
    logic [31:0] instret_o;
    logic        misalign_o;

    logic [31:0] s_pc, s_pc_prev, s_pc_ret;
    logic [2:0]  s_instret;
    logic        s_misalign;

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    localparam logic [2:0] FETCH = 3'b000;
    localparam logic [2:0] DECODE = 3'b010;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .rst(rst), .estado(estado), .pcsrc(pcsrc),
        .immediate(immediate), .rs1(rs1), .stall(stall),
        .PC(pc_o), .pc_prev(pc_prev_o), .pc_ret(pc_ret_o),
        .instret(instret_o), .misalign(misalign_o)
    );

    pc_unit #(.CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .estado(estado), .pcsrc(pcsrc),
        .immediate(immediate), .rs1(rs1), .stall(stall),
        .PC(s_pc), .pc_prev(s_pc_prev), .pc_ret(s_pc_ret),
        .instret(s_instret), .misalign(s_misalign)
    );

    // Single comparison point: counts and reports any mismatch.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, sample 1 ns later.
    task automatic step(input logic r, input logic [2:0] st, input logic [1:0] sel,
                        input logic [12:0] imm, input logic [31:0] r1, input logic stl);
        rst = r; estado = st; pcsrc = sel; immediate = imm; rs1 = r1; stall = stl;
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d: rst=%0b estado=%0b pcsrc=%0b imm=%0h rs1=%0h stall=%0b -> PC=%0h prev=%0h ret=%0h instret=%0d mis=%0b",
                 n_txn, r, st, sel, imm, r1, stl, pc_o, pc_prev_o, pc_ret_o, instret_o, misalign_o);
    endtask

    initial begin
        rst = 1'b1; estado = FETCH; pcsrc = 2'b00; immediate = '0; rs1 = '0; stall = 1'b0;

        // Reset state
        step(1'b1, FETCH, 2'b00, 13'h0, 32'h0, 1'b0);
        step(1'b1, FETCH, 2'b00, 13'h0, 32'h0, 1'b0);
        check_val("rst_pc",       pc_o,       32'h0);
        check_val("rst_prev",     pc_prev_o,  32'h0);
        check_val("rst_instret",  instret_o,  32'h0);
        check_val("rst_misalign", misalign_o, 1'b0);
        check_val("rst_ret",      pc_ret_o,   32'h4);

        // Four sequential fetches
        step(1'b0, FETCH, 2'b00, 13'h0, 32'h0, 1'b0);
        check_val("seq1_pc", pc_o, 32'h4);
        check_val("seq1_prev", pc_prev_o, 32'h0);
        step(1'b0, FETCH, 2'b00, 13'h0, 32'h0, 1'b0);
        check_val("seq2_pc", pc_o, 32'h8);
        step(1'b0, FETCH, 2'b00, 13'h0, 32'h0, 1'b0);
        check_val("seq3_pc", pc_o, 32'hC);
        step(1'b0, FETCH, 2'b00, 13'h0, 32'h0, 1'b0);
        check_val("seq4_pc", pc_o, 32'h10);
        check_val("seq4_prev", pc_prev_o, 32'hC);
        check_val("seq4_instret", instret_o, 32'd4);
        check_val("seq4_ret", pc_ret_o, 32'h14);

        // jalr to 0x100, then relative branch by -8
        step(1'b0, FETCH, 2'b10, 13'h0, 32'h100, 1'b0);
        check_val("jalr100_pc", pc_o, 32'h100);
        check_val("jalr100_prev", pc_prev_o, 32'h10);
        step(1'b0, FETCH, 2'b01, 13'h1FF8, 32'h0, 1'b0);
        check_val("rel_neg_pc", pc_o, 32'hF8);
        check_val("rel_neg_prev", pc_prev_o, 32'h100);
        check_val("rel_neg_ret", pc_ret_o, 32'hFC);
        check_val("rel_neg_instret", instret_o, 32'd6);

        // jalr with bit0 cleared: 0x2001 + 4 = 0x2005 -> 0x2004
        step(1'b0, FETCH, 2'b10, 13'h4, 32'h2001, 1'b0);
        check_val("jalr_pc", pc_o, 32'h2004);
        check_val("jalr_prev", pc_prev_o, 32'hF8);
        check_val("jalr_instret", instret_o, 32'd7);

        // Stall and non-fetch states block updates
        step(1'b0, FETCH,  2'b00, 13'h0, 32'h0, 1'b1);
        step(1'b0, DECODE, 2'b01, 13'h8, 32'h0, 1'b0);
        step(1'b0, FETCH,  2'b10, 13'h8, 32'h40, 1'b1);
        check_val("stall_pc", pc_o, 32'h2004);
        check_val("stall_prev", pc_prev_o, 32'hF8);
        check_val("stall_instret", instret_o, 32'd7);

        // Explicit hold in fetch is not an update
        step(1'b0, FETCH, 2'b11, 13'h8, 32'h0, 1'b0);
        step(1'b0, FETCH, 2'b11, 13'h8, 32'h0, 1'b0);
        check_val("hold_pc", pc_o, 32'h2004);
        check_val("hold_instret", instret_o, 32'd7);
        check_val("small_cnt7", s_instret, 3'd7);

        // Relative with zero offset: self-loop still counts; small counter wraps 7->0
        step(1'b0, FETCH, 2'b01, 13'h0, 32'h0, 1'b0);
        check_val("self_pc", pc_o, 32'h2004);
        check_val("self_prev", pc_prev_o, 32'h2004);
        check_val("self_instret", instret_o, 32'd8);
        check_val("small_cnt_wrap", s_instret, 3'd0);

        // Top-of-address-space wrap
        step(1'b0, FETCH, 2'b10, 13'h0, 32'hFFFF_FFFC, 1'b0);
        check_val("top_pc", pc_o, 32'hFFFF_FFFC);
        check_val("top_ret_wrap", pc_ret_o, 32'h0);
        step(1'b0, FETCH, 2'b00, 13'h0, 32'h0, 1'b0);
        check_val("wrap_pc", pc_o, 32'h0);
        check_val("wrap_prev", pc_prev_o, 32'hFFFF_FFFC);
        check_val("wrap_instret", instret_o, 32'd10);

        // Misaligned relative target
        step(1'b0, FETCH, 2'b10, 13'h0, 32'h100, 1'b0);
        check_val("mis_setup_pc", pc_o, 32'h100);
        step(1'b0, FETCH, 2'b01, 13'h6, 32'h0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
        check_val("mis_pc", pc_o, 32'h40);
        check_val("mis_flag", misalign_o, 1'b1);
`else
        check_val("mis_pc", pc_o, 32'h106);
        check_val("mis_flag", misalign_o, 1'b0);
`endif
        check_val("mis_prev", pc_prev_o, 32'h100);
        check_val("mis_instret", instret_o, 32'd12);
        step(1'b0, FETCH, 2'b11, 13'h0, 32'h0, 1'b0);
        check_val("mis_clear", misalign_o, 1'b0);

        // Reset asserted during a fetch with a branch pending
        step(1'b1, FETCH, 2'b01, 13'h8, 32'h0, 1'b0);
        check_val("midrst_pc", pc_o, 32'h0);
        check_val("midrst_prev", pc_prev_o, 32'h0);
        check_val("midrst_instret", instret_o, 32'd0);
        step(1'b0, FETCH, 2'b00, 13'h0, 32'h0, 1'b0);
        check_val("post_rst_pc", pc_o, 32'h4);
        check_val("post_rst_instret", instret_o, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
